trig_cmd_decoder: RTL and testbench
===================================

Name: trig_cmd_decoder

Overview:
Byte-level SUMP command decoder that drives the configuration and control inputs of the trigger stages (cmd, set_mask/set_val/set_cfg strobes, arm). It sits between the UART receiver and the stage array, turning 1-byte short and 5-byte long commands into single-cycle strobes plus a registered 32-bit payload. Non-trigger commands are forwarded generically to the rest of the core.

Parameters:
NUM_STAGES, 4, number of trigger stages served (1..4); one strobe bit per stage on each set_* output.
TIMEOUT_CYCLES, 1000000, inter-byte idle limit inside a long command (used only with CMD_TIMEOUT_EN).

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous, active-high reset
rx_data_i  input  8  received byte
rx_stb_i  input  1  rx_data_i valid, one-cycle pulse per byte
cmd_o  output  32  payload of last completed long command, {b4,b3,b2,b1}, b1 first received
opc_o  output  8  opcode of last completed command (short or long)
set_mask_o  output  NUM_STAGES  one-cycle strobe: load mask into stage i
set_val_o  output  NUM_STAGES  one-cycle strobe: load value into stage i
set_cfg_o  output  NUM_STAGES  one-cycle strobe: load config into stage i
arm_o  output  1  one-cycle strobe: opcode 0x01
sw_rst_o  output  1  one-cycle strobe: opcode 0x00
short_stb_o  output  1  one-cycle strobe: any other short opcode (bit7 = 0)
long_stb_o  output  1  one-cycle strobe: every completed long command
busy_o  output  1  high while collecting long-command payload bytes
timeout_o  output  1  one-cycle strobe: long command aborted (CMD_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (rst_i high at clk edge): FSM to IDLE, byte counter 0, cmd_o/opc_o 0x0, all strobes and busy_o 0. Reset mid-command discards collected bytes.
- FSM states: IDLE, LONG.
- IDLE + rx_stb_i, rx_data_i[7]=0: opc_o <= byte; next cycle exactly one of sw_rst_o (0x00), arm_o (0x01), short_stb_o (else) high for one cycle; stay IDLE.
- IDLE + rx_stb_i, rx_data_i[7]=1: latch opcode into an internal register, counter <= 0, go LONG, busy_o high from next cycle.
- LONG + rx_stb_i: shift byte into payload, little-endian (byte k -> bits 8k+7:8k); counter increments. On 4th byte: cmd_o and opc_o update, return IDLE, busy_o low; strobes high the following cycle.
- Bytes in LONG are data regardless of value (0x00 in payload does not trigger sw_rst_o).
- Long-command decode (1 cycle after 4th byte): long_stb_o always. If opc[7:4]=0xC: stage s=opc[3:2], type=opc[1:0]: 00 -> set_mask_o[s], 01 -> set_val_o[s], 10 -> set_cfg_o[s], 11 -> no stage strobe. If s >= NUM_STAGES: no stage strobe.
- Latency: last byte strobe at cycle N -> strobe(s) at N+1; cmd_o/opc_o valid at N+1 and held until next command completes.
- Back-to-back: a new byte may arrive on N+1 (rx_stb_i every cycle) and is accepted; no bytes lost at full rate.
- All strobes mutually exclusive except long_stb_o, which accompanies a stage strobe.

Optional Feature:
CMD_TIMEOUT_EN: when defined, a counter resets on entry to LONG and on each rx_stb_i; if it reaches TIMEOUT_CYCLES with no byte, FSM returns to IDLE, payload discarded, no command strobes, cmd_o/opc_o unchanged, timeout_o pulses one cycle. A byte arriving on the timeout cycle has priority (counter resets, no timeout). Without the macro: LONG waits indefinitely, timeout_o constant 0, no counter synthesised.

Test Plan:
- After reset, bytes 0xC4,0x78,0x56,0x34,0x12 -> one cycle after last byte: cmd_o=0x12345678, opc_o=0xC4, set_mask_o=4'b0010, long_stb_o=1, all else 0.
- Bytes 0x01 then 0x00 on consecutive cycles -> arm_o pulse, then sw_rst_o pulse next cycle; busy_o stays 0.
- 0xC9,0x00,0x00,0x00,0x00 at full rate immediately followed by 0xCE,... -> set_val_o[2] pulse, cmd_o=0x0; second command decoded with zero gaps, set_cfg_o[3] pulse.
- NUM_STAGES=2, bytes 0xCA + 4 payload bytes -> long_stb_o pulses, set_cfg_o=2'b00; 0x81 + 4 bytes -> long_stb_o only, opc_o=0x81.
- rst_i asserted after 2 of 4 payload bytes, then 0x02 -> no long strobes, short_stb_o pulse with opc_o=0x02.
- CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: 0xC0 + 2 bytes, then 16 idle cycles -> timeout_o pulse, busy_o low, no set_mask_o; following 0x01 -> arm_o.

Source files
------------

// File: rtl/trig_cmd_decoder.sv
// SUMP byte-stream command decoder: 1-byte short and 5-byte long commands turned into
// single-cycle trigger-stage strobes. Define CMD_TIMEOUT_EN to abort stalled long commands.
module trig_cmd_decoder #(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_stb_i,
  output logic [31:0]           cmd_o,
  output logic [7:0]            opc_o,
  output logic [NUM_STAGES-1:0] set_mask_o,
  output logic [NUM_STAGES-1:0] set_val_o,
  output logic [NUM_STAGES-1:0] set_cfg_o,
  output logic                  arm_o,
  output logic                  sw_rst_o,
  output logic                  short_stb_o,
  output logic                  long_stb_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  typedef enum logic {IDLE, LONG} state_t;

  state_t                  state;
  logic [7:0]              lopc;
  logic [23:0]             payload;
  logic [1:0]              cnt;
  logic [NUM_STAGES-1:0]   stage_sel;
  logic                    expire;

  if (NUM_STAGES < 1 || NUM_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("trig_cmd_decoder: NUM_STAGES must be 1..4 and TIMEOUT_CYCLES at least 1");
  end

  // Stage numbers beyond NUM_STAGES match no bit, so those commands strobe no stage.
  always_comb begin
    stage_sel = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++)
      stage_sel[i] = (lopc[3:2] == 2'(i));
  end

`ifdef CMD_TIMEOUT_EN
  logic [31:0] idle_cnt;

  always_comb
    expire = (state == LONG) && !rx_stb_i && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= expire;
      if (state == IDLE || rx_stb_i || expire)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  always_comb expire = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      lopc        <= '0;
      payload     <= '0;
      cnt         <= '0;
      cmd_o       <= '0;
      opc_o       <= '0;
      set_mask_o  <= '0;
      set_val_o   <= '0;
      set_cfg_o   <= '0;
      arm_o       <= 1'b0;
      sw_rst_o    <= 1'b0;
      short_stb_o <= 1'b0;
      long_stb_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      set_mask_o  <= '0;
      set_val_o   <= '0;
      set_cfg_o   <= '0;
      arm_o       <= 1'b0;
      sw_rst_o    <= 1'b0;
      short_stb_o <= 1'b0;
      long_stb_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_stb_i) begin
            if (!rx_data_i[7]) begin
              opc_o <= rx_data_i;
              case (rx_data_i)
                8'h00:   sw_rst_o    <= 1'b1;
                8'h01:   arm_o       <= 1'b1;
                default: short_stb_o <= 1'b1;
              endcase
            end else begin
              lopc   <= rx_data_i;
              cnt    <= '0;
              busy_o <= 1'b1;
              state  <= LONG;
            end
          end
        end
        LONG: begin
          if (rx_stb_i) begin
            cnt     <= cnt + 2'd1;
            payload <= {rx_data_i, payload[23:8]};
            if (cnt == 2'd3) begin
              cmd_o      <= {rx_data_i, payload};
              opc_o      <= lopc;
              long_stb_o <= 1'b1;
              busy_o     <= 1'b0;
              state      <= IDLE;
              if (lopc[7:4] == 4'hC) begin
                case (lopc[1:0])
                  2'b00:   set_mask_o <= stage_sel;
                  2'b01:   set_val_o  <= stage_sel;
                  2'b10:   set_cfg_o  <= stage_sel;
                  default: ;
                endcase
              end
            end
          end else if (expire) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_cmd_decoder.sv
// Directed bench for trig_cmd_decoder: a 4-stage (timeout 16) and a 2-stage instance
// share one byte stream.
module tb_trig_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_stb;

  logic [31:0] cmd;
  logic [7:0]  opc;
  logic [3:0]  set_mask, set_val, set_cfg;
  logic        arm, sw_rst, short_stb, long_stb, busy, timeout;

  logic [31:0] cmd2;
  logic [7:0]  opc2;
  logic [1:0]  set_mask2, set_val2, set_cfg2;
  logic        arm2, sw_rst2, short_stb2, long_stb2, busy2, timeout2;

  int n_checks = 0;
  int n_errors = 0;

  trig_cmd_decoder #(.NUM_STAGES(4), .TIMEOUT_CYCLES(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_stb_i(rx_stb),
    .cmd_o(cmd), .opc_o(opc), .set_mask_o(set_mask), .set_val_o(set_val),
    .set_cfg_o(set_cfg), .arm_o(arm), .sw_rst_o(sw_rst), .short_stb_o(short_stb),
    .long_stb_o(long_stb), .busy_o(busy), .timeout_o(timeout)
  );

  trig_cmd_decoder #(.NUM_STAGES(2), .TIMEOUT_CYCLES(16)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_stb_i(rx_stb),
    .cmd_o(cmd2), .opc_o(opc2), .set_mask_o(set_mask2), .set_val_o(set_val2),
    .set_cfg_o(set_cfg2), .arm_o(arm2), .sw_rst_o(sw_rst2), .short_stb_o(short_stb2),
    .long_stb_o(long_stb2), .busy_o(busy2), .timeout_o(timeout2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] strobes();
    return {19'd0, arm, sw_rst, short_stb, long_stb, timeout, set_mask, set_val, set_cfg};
  endfunction

  logic [7:0] stream [10];

  initial begin
    rx_data = 8'h00;
    rx_stb  = 1'b0;
    rst     = 1'b1;
    idle(3);
    check("rst_cmd", cmd, 32'h0);
    check("rst_opc", {24'd0, opc}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_strobes", strobes(), 32'h0);
    rst = 1'b0;

    // long set_mask command to stage 1
    send(8'hC4);
    check("t1_busy", {31'd0, busy}, 32'h1);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    check("t1_cmd", cmd, 32'h12345678);
    check("t1_opc", {24'd0, opc}, 32'hC4);
    check("t1_mask", {28'd0, set_mask}, 32'h2);
    check("t1_long", {31'd0, long_stb}, 32'h1);
    check("t1_others", {27'd0, arm, sw_rst, short_stb, busy, timeout}, 32'h0);
    check("t1_val_cfg", {24'd0, set_val, set_cfg}, 32'h0);
    check("t1_mask2", {30'd0, set_mask2}, 32'h2);
    idle(1);
    check("t1_after_strobes", strobes(), 32'h0);
    check("t1_cmd_held", cmd, 32'h12345678);

    // arm then sw_rst at full rate
    @(negedge clk); rx_data = 8'h01; rx_stb = 1'b1;
    @(negedge clk); rx_data = 8'h00;
    check("t2_arm", {31'd0, arm}, 32'h1);
    check("t2_opc_arm", {24'd0, opc}, 32'h01);
    check("t2_busy_a", {31'd0, busy}, 32'h0);
    @(negedge clk); rx_stb = 1'b0;
    check("t2_swrst", {29'd0, arm, sw_rst, short_stb}, 32'h2);
    check("t2_opc_rst", {24'd0, opc}, 32'h00);
    check("t2_busy_b", {31'd0, busy}, 32'h0);

    // two long commands back-to-back with no gaps
    stream = '{8'hC9, 8'h00, 8'h00, 8'h00, 8'h00, 8'hCE, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) check("t3_busy", {31'd0, busy}, 32'h1);
      if (i == 5) begin
        check("t3_val", {28'd0, set_val}, 32'h4);
        check("t3_cmd0", cmd, 32'h0);
        check("t3_opc0", {24'd0, opc}, 32'hC9);
        check("t3_long0", {31'd0, long_stb}, 32'h1);
        check("t3_no_swrst", {31'd0, sw_rst}, 32'h0);
        check("t3_busy_low", {31'd0, busy}, 32'h0);
        check("t3_val2", {30'd0, set_val2}, 32'h0);
      end
      rx_data = stream[i];
      rx_stb  = 1'b1;
    end
    @(negedge clk); rx_stb = 1'b0;
    check("t3_cfg", {28'd0, set_cfg}, 32'h8);
    check("t3_cmd1", cmd, 32'hDEADBEEF);
    check("t3_opc1", {24'd0, opc}, 32'hCE);
    check("t3_cfg2", {30'd0, set_cfg2}, 32'h0);
    check("t3_long2", {31'd0, long_stb2}, 32'h1);

    // out-of-range stage on the 2-stage instance, then a non-trigger long command
    send(8'hCA); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("t4_cfg", {28'd0, set_cfg}, 32'h4);
    check("t4_cfg2", {30'd0, set_cfg2}, 32'h0);
    check("t4_long2", {31'd0, long_stb2}, 32'h1);
    check("t4_cmd2", cmd2, 32'h44332211);
    send(8'h81); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("t4_long", {31'd0, long_stb}, 32'h1);
    check("t4_opc", {24'd0, opc}, 32'h81);
    check("t4_cmd", cmd, 32'h04030201);
    check("t4_stage", {20'd0, set_mask, set_val, set_cfg}, 32'h0);

    // reset in the middle of a long command
    send(8'hC0); send(8'hAA); send(8'hBB);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'h0);
    check("t5_cmd_clr", cmd, 32'h0);
    send(8'h02);
    check("t5_short", {29'd0, short_stb, long_stb, arm}, 32'h4);
    check("t5_opc", {24'd0, opc}, 32'h02);
    check("t5_mask", {28'd0, set_mask}, 32'h0);

    // stalled long command
    send(8'hC0); send(8'h11); send(8'h22);
    idle(15);
    check("t6_busy_wait", {31'd0, busy}, 32'h1);
    check("t6_no_timeout", {31'd0, timeout}, 32'h0);
`ifdef CMD_TIMEOUT_EN
    idle(1);
    check("t6_timeout", {31'd0, timeout}, 32'h1);
    check("t6_busy_low", {31'd0, busy}, 32'h0);
    check("t6_mask", {27'd0, set_mask, long_stb}, 32'h0);
    check("t6_opc_held", {24'd0, opc}, 32'h02);
    idle(1);
    check("t6_timeout_pulse", {31'd0, timeout}, 32'h0);
`else
    idle(5);
    check("t6_busy_still", {31'd0, busy}, 32'h1);
    check("t6_timeout_zero", {31'd0, timeout}, 32'h0);
    send(8'h33); send(8'h44);
    check("t6_mask", {28'd0, set_mask}, 32'h1);
    check("t6_cmd", cmd, 32'h44332211);
    check("t6_opc", {24'd0, opc}, 32'hC0);
`endif
    send(8'h01);
    check("t6_arm", {31'd0, arm}, 32'h1);
    check("t6_opc_arm", {24'd0, opc}, 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
